compress_sched: RTL and testbench
=================================

# compress_sched

Slice-level scheduler for the compression datapath. It ingests the per-slice counter stream, classifies each slice by how many of its counters are large, and dispatches the slice to either the tower-encoding engine or the sketch-sensing engine. It then waits for that engine's completion before moving to the next slice. It sits between the counter source and the two engines inside the compress top level, and sequences one frame of NUM_SLICE slices per Frame_start.

## Interface
Parameters:
- NUM_COUNTER, 10, counters per slice
- NUM_SLICE, 3, slices per frame
- THRESHOLD, 30, a counter is "large" when its value is ≥ THRESHOLD (unsigned 32-bit compare)
- SENSE_COL, 3, maximum large-counter count routable to sketch sensing
- TIMEOUT_CYC, 64, watchdog limit; used only when COMPRESS_TIMEOUT_EN is defined

Ports (SW = clog2(NUM_SLICE)):
- SYS_CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- Frame_start  in  1  one-cycle request to process one frame
- Counter_valid  in  1  Counter word is valid
- Counter  in  32  counter value
- Counter_ready  out  1  scheduler accepts Counter this cycle
- Te_start  out  1  one-cycle start pulse to the tower-encoding engine
- Te_slice  out  SW  slice index for Te_start
- Te_done  in  1  tower-encoding engine completion pulse
- Ss_start  out  1  one-cycle start pulse to the sketch-sensing engine
- Ss_slice  out  SW  slice index for Ss_start
- Ss_done  in  1  sketch-sensing engine completion pulse
- Route_map  out  NUM_SLICE  bit s set to 1 means slice s went to sensing
- Busy  out  1  high in every state except IDLE
- Frame_done  out  1  one-cycle pulse at end of frame
- Err_timeout  out  1  sticky watchdog flag (tied 0 without macro)

## Operation
- States: IDLE, INGEST, DECIDE, ISSUE, WAIT, DONE.
- IDLE:
  - Frame_start=1 → INGEST.
  - Clear slice index, counter index, large_cnt, Route_map and Err_timeout.
  - Frame_start outside IDLE is ignored.
- INGEST:
  - Counter_ready=1.
  - A word is accepted on each edge with Counter_valid & Counter_ready.
  - large_cnt (width clog2(NUM_COUNTER+1)) increments when Counter ≥ THRESHOLD.
  - Counter_valid=0 stalls with no state change.
  - The accept of word NUM_COUNTER-1 → DECIDE.
- DECIDE (1 cycle):
  - Counter_ready=0.
  - route = (large_cnt ≤ SENSE_COL).
  - Route_map[slice] ← route.
  - → ISSUE.
- ISSUE (1 cycle):
  - Assert Ss_start if route=1, otherwise Te_start.
  - Drive the matching *_slice with the slice index.
  - The other start output and its slice output stay 0.
  - → WAIT.
- WAIT:
  - Sample only the done of the selected engine; the other engine's done is ignored.
  - On done: if slice = NUM_SLICE-1 → DONE; otherwise slice+1, counter index and large_cnt cleared → INGEST.
- DONE: Frame_done=1 for one cycle → IDLE. Route_map holds until the next accepted Frame_start.
- A done pulse arriving in any state other than WAIT is dropped.

## Timing
- Reset values: all outputs 0, state IDLE, all internal counters 0. Reset asserted mid-frame aborts immediately; no done is awaited.
- All outputs are registered. Busy rises the cycle after Frame_start is sampled.
- Per slice, with continuous valid and done in the first WAIT cycle: NUM_COUNTER + 3 cycles (INGEST N, DECIDE 1, ISSUE 1, WAIT 1).
- Frame: Frame_start sampled at cycle 0 → Frame_done high at cycle 1 + NUM_SLICE·(NUM_COUNTER+3). With defaults this is cycle 40.
- Earliest legal done is the cycle after the start pulse.
- RESET and Frame_start in the same cycle: reset wins.

## Configuration
- COMPRESS_TIMEOUT_EN defined:
  - A wait counter runs in WAIT.
  - If no selected done arrives within TIMEOUT_CYC cycles, Err_timeout is set (sticky until the next Frame_start) and the FSM → IDLE without a Frame_done pulse.
- Not defined: no wait counter, WAIT holds indefinitely, Err_timeout tied 0.

## Test plan
- Slice 0 all counters 5, engine done 1 cycle later → Ss_start with Ss_slice=0, Te_start stays 0, Route_map[0]=1.
- Slice with 4 counters equal to 30 (the rest 0) → large_cnt=4 > 3 → Te_start, Route_map bit 0. This checks that the ≥ THRESHOLD boundary counts as large.
- Slice with exactly 3 counters of 100 → Ss_start (SENSE_COL boundary is inclusive).
- Full default frame, route pattern sense/tower/sense, zero-wait engines → Frame_done at cycle 40 after Frame_start, Route_map=3'b101, Busy low the cycle after Frame_done.
- RESET pulsed during WAIT of slice 1 → all outputs 0 in the same cycle. The next Frame_start restarts at slice 0 with Route_map cleared.
- With COMPRESS_TIMEOUT_EN, Te_done withheld → Err_timeout=1 after 64 WAIT cycles, return to IDLE, no Frame_done. A stray Ss_done during the same WAIT is ignored.

Source files
------------

// File: rtl/compress_sched.sv
// compress_sched: classifies each slice of a frame by its large-counter count and dispatches it
// to the tower-encoding or sketch-sensing engine. Define COMPRESS_TIMEOUT_EN for the wait watchdog.

module compress_sched #(
  parameter int          NUM_COUNTER = 10,
  parameter int          NUM_SLICE   = 3,
  parameter logic [31:0] THRESHOLD   = 32'd30,
  parameter int          SENSE_COL   = 3
`ifdef COMPRESS_TIMEOUT_EN
  , parameter int        TIMEOUT_CYC = 64
`endif
) (
  input  logic                         SYS_CLK,
  input  logic                         RESET,
  input  logic                         Frame_start,
  input  logic                         Counter_valid,
  input  logic [31:0]                  Counter,
  output logic                         Counter_ready,
  output logic                         Te_start,
  output logic [$clog2(NUM_SLICE)-1:0] Te_slice,
  input  logic                         Te_done,
  output logic                         Ss_start,
  output logic [$clog2(NUM_SLICE)-1:0] Ss_slice,
  input  logic                         Ss_done,
  output logic [NUM_SLICE-1:0]         Route_map,
  output logic                         Busy,
  output logic                         Frame_done,
  output logic                         Err_timeout
);

  localparam int SW = $clog2(NUM_SLICE);
  localparam int CW = (NUM_COUNTER > 1) ? $clog2(NUM_COUNTER) : 1;
  localparam int LW = $clog2(NUM_COUNTER + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INGEST, S_DECIDE, S_ISSUE, S_WAIT, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        slice_q, slice_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        large_q, large_d;
  logic                 route_q, route_d;
  logic [NUM_SLICE-1:0] route_map_q, route_map_d;
  logic                 te_start_q, te_start_d, ss_start_q, ss_start_d;
  logic [SW-1:0]        te_slice_q, te_slice_d, ss_slice_q, ss_slice_d;
  logic                 ready_q, ready_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic                 accept, is_large, done_sel;
`ifdef COMPRESS_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
`endif

  assign accept   = Counter_valid & ready_q;
  assign is_large = (Counter >= THRESHOLD);
  assign done_sel = route_q ? Ss_done : Te_done;

  // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    slice_d     = slice_q;
    cnt_d       = cnt_q;
    large_d     = large_q;
    route_d     = route_q;
    route_map_d = route_map_q;
`ifdef COMPRESS_TIMEOUT_EN
    wait_d      = wait_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: if (Frame_start) begin
        slice_d     = '0;
        cnt_d       = '0;
        large_d     = '0;
        route_map_d = '0;
`ifdef COMPRESS_TIMEOUT_EN
        err_d       = 1'b0;
`endif
        state_d     = S_INGEST;
      end
      S_INGEST: if (accept) begin
        if (is_large) large_d = large_q + LW'(1);
        if (cnt_q == CW'(NUM_COUNTER - 1)) state_d = S_DECIDE;
        else                               cnt_d   = cnt_q + CW'(1);
      end
      S_DECIDE: begin
        route_d              = (32'(large_q) <= 32'(SENSE_COL));
        route_map_d[slice_q] = route_d;
        state_d              = S_ISSUE;
      end
      S_ISSUE: begin
`ifdef COMPRESS_TIMEOUT_EN
        wait_d  = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_sel) begin
          if (slice_q == SW'(NUM_SLICE - 1)) begin
            state_d = S_DONE;
          end else begin
            slice_d = slice_q + SW'(1);
            cnt_d   = '0;
            large_d = '0;
            state_d = S_INGEST;
          end
        end
`ifdef COMPRESS_TIMEOUT_EN
        else if (wait_q == WW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    ready_d      = (state_d == S_INGEST);
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);
    ss_start_d   = (state_d == S_ISSUE) &&  route_d;
    te_start_d   = (state_d == S_ISSUE) && !route_d;
    ss_slice_d   = ss_start_d ? slice_q : '0;
    te_slice_d   = te_start_d ? slice_q : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      slice_q      <= '0;
      cnt_q        <= '0;
      large_q      <= '0;
      route_q      <= 1'b0;
      route_map_q  <= '0;
      te_start_q   <= 1'b0;
      ss_start_q   <= 1'b0;
      te_slice_q   <= '0;
      ss_slice_q   <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef COMPRESS_TIMEOUT_EN
      wait_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      slice_q      <= slice_d;
      cnt_q        <= cnt_d;
      large_q      <= large_d;
      route_q      <= route_d;
      route_map_q  <= route_map_d;
      te_start_q   <= te_start_d;
      ss_start_q   <= ss_start_d;
      te_slice_q   <= te_slice_d;
      ss_slice_q   <= ss_slice_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef COMPRESS_TIMEOUT_EN
      wait_q       <= wait_d;
      err_q        <= err_d;
`endif
    end
  end

  assign Counter_ready = ready_q;
  assign Te_start      = te_start_q;
  assign Te_slice      = te_slice_q;
  assign Ss_start      = ss_start_q;
  assign Ss_slice      = ss_slice_q;
  assign Route_map     = route_map_q;
  assign Busy          = busy_q;
  assign Frame_done    = frame_done_q;
`ifdef COMPRESS_TIMEOUT_EN
  assign Err_timeout   = err_q;
`else
  assign Err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_compress_sched.sv
// Self-checking bench for compress_sched: directed test-plan frames plus randomized frames
// checked against a slice-level reference model (route rule and frame latency formula).

module tb_compress_sched;

  localparam int          NC = 10;
  localparam int          NS = 3;
  localparam int unsigned TH = 30;
  localparam int          SC = 3;

  logic          SYS_CLK = 1'b0;
  logic          RESET, Frame_start, Counter_valid, Te_done, Ss_done;
  logic [31:0]   Counter;
  logic          Counter_ready, Te_start, Ss_start, Busy, Frame_done, Err_timeout;
  logic [1:0]    Te_slice, Ss_slice;
  logic [NS-1:0] Route_map;

  compress_sched dut (
    .SYS_CLK(SYS_CLK), .RESET(RESET), .Frame_start(Frame_start),
    .Counter_valid(Counter_valid), .Counter(Counter), .Counter_ready(Counter_ready),
    .Te_start(Te_start), .Te_slice(Te_slice), .Te_done(Te_done),
    .Ss_start(Ss_start), .Ss_slice(Ss_slice), .Ss_done(Ss_done),
    .Route_map(Route_map), .Busy(Busy), .Frame_done(Frame_done), .Err_timeout(Err_timeout)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int unsigned cnt_val [NS][NC];
  int          gap     [NS][NC];
  int          dly     [NS];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic idle_inputs();
    Frame_start   = 1'b0;
    Counter_valid = 1'b0;
    Counter       = '0;
    Te_done       = 1'b0;
    Ss_done       = 1'b0;
  endtask

  // Reference model: a slice goes to sensing when at most SC of its counters are >= TH.
  function automatic bit exp_route(int s);
    int n = 0;
    for (int w = 0; w < NC; w++) if (cnt_val[s][w] >= TH) n++;
    return (n <= SC);
  endfunction

  // Frame_done cycle: 1 + per slice (ingest words + stall cycles + decide + issue + engine latency).
  function automatic int exp_frame_cyc();
    int t = 1;
    for (int s = 0; s < NS; s++) begin
      t += NC + 2 + dly[s];
      for (int w = 0; w < NC; w++) t += gap[s][w];
    end
    return t;
  endfunction

  function automatic void fill_directed();
    for (int w = 0; w < NC; w++) begin
      cnt_val[0][w] = 5;
      cnt_val[1][w] = (w < 4) ? 30 : 0;
      cnt_val[2][w] = (w < 3) ? 100 : 0;
      for (int s = 0; s < NS; s++) gap[s][w] = 0;
    end
    for (int s = 0; s < NS; s++) dly[s] = 1;
  endfunction

  function automatic void fill_random();
    for (int s = 0; s < NS; s++) begin
      int p = $urandom_range(0, 9);
      for (int w = 0; w < NC; w++) begin
        if ($urandom_range(0, 9) < p)
          cnt_val[s][w] = ($urandom_range(0, 2) == 0) ? TH :
                          ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : TH + $urandom_range(0, 1000);
        else
          cnt_val[s][w] = ($urandom_range(0, 2) == 0) ? TH - 1 : $urandom_range(0, TH - 1);
        gap[s][w] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      dly[s] = $urandom_range(1, 4);
    end
  endfunction

  // Runs one frame with a counter source and two engine models. With abort_slice >= 0 it
  // returns in the cycle that slice's start pulse is seen; ev_cyc is that cycle or Frame_done's.
  task automatic run_frame(input int abort_slice, output int ev_cyc);
    int          exp_cyc = exp_frame_cyc();
    logic [NS-1:0] exp_map = '0;
    int          k = 1, starts = 0, done_cyc = -1, drv_s = 0, drv_w = 0, gap_left;
    bit          done_ss = 1'b0, acc_pending = 1'b0, finished = 1'b0, r;
    for (int s = 0; s < NS; s++) exp_map[s] = exp_route(s);
    gap_left = gap[0][0];
    ev_cyc   = -1;
    idle_inputs();
    Frame_start = 1'b1;
    step();
    check("busy_rise", {31'd0, Busy}, 32'd1);
    while (k <= exp_cyc + 20 && !finished) begin
      if (Te_start || Ss_start) begin
        r = (starts < NS) ? exp_route(starts) : 1'b0;
        check("start_sel", {30'd0, Ss_start, Te_start}, r ? 32'd2 : 32'd1);
        check("start_slice", {30'd0, (Ss_start ? Ss_slice : Te_slice)}, starts);
        check("other_slice", {30'd0, (Ss_start ? Te_slice : Ss_slice)}, 32'd0);
        if (starts == abort_slice) begin
          idle_inputs();
          ev_cyc = k;
          return;
        end
        done_cyc = k + dly[starts];
        done_ss  = r;
        starts++;
      end
      if (Frame_done) begin
        ev_cyc = k;
        check("frame_done_cyc", k, exp_cyc);
        check("route_map", {29'd0, Route_map}, {29'd0, exp_map});
        check("slices_issued", starts, NS);
        check("err_clear", {31'd0, Err_timeout}, 32'd0);
        idle_inputs();
        step();
        check("busy_fall", {31'd0, Busy}, 32'd0);
        check("frame_done_pulse", {31'd0, Frame_done}, 32'd0);
        finished = 1'b1;
      end else begin
        if (acc_pending) begin
          drv_w++;
          if (drv_w == NC) begin drv_w = 0; drv_s++; end
          gap_left = (drv_s < NS) ? gap[drv_s][drv_w] : 0;
        end
        acc_pending = 1'b0;
        if (Counter_ready) begin
          if (gap_left > 0) begin
            Counter_valid = 1'b0;
            gap_left--;
          end else begin
            Counter_valid = 1'b1;
            Counter       = (drv_s < NS) ? cnt_val[drv_s][drv_w] : 32'd0;
            acc_pending   = 1'b1;
          end
        end else begin
          // Large junk offered while not ready must never be counted.
          Counter_valid = 1'($urandom_range(0, 1));
          Counter       = 32'hFFFF_FFFF;
        end
        Te_done = (k == done_cyc) && !done_ss;
        Ss_done = (k == done_cyc) &&  done_ss;
        if (k != done_cyc && $urandom_range(0, 3) == 0) begin
          if (done_cyc > k) begin
            if (done_ss) Te_done = 1'b1; else Ss_done = 1'b1;
          end else if ($urandom_range(0, 1) == 0) Te_done = 1'b1;
          else                                    Ss_done = 1'b1;
        end
        Frame_start = ($urandom_range(0, 7) == 0);
        step();
        k++;
      end
    end
    if (!finished) check("frame_done_seen", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ev;
    RESET = 1'b1;
    idle_inputs();
    repeat (2) step();
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_ready", {31'd0, Counter_ready}, 32'd0);
    check("rst_starts", {30'd0, Te_start, Ss_start}, 32'd0);
    check("rst_slices", {28'd0, Te_slice, Ss_slice}, 32'd0);
    check("rst_map", {29'd0, Route_map}, 32'd0);
    check("rst_done_err", {30'd0, Frame_done, Err_timeout}, 32'd0);
    RESET = 1'b0;
    step();

    // Test-plan frame: sense (all 5), tower (4 x 30), sense (3 x 100), zero-wait engines.
    fill_directed();
    run_frame(-1, ev);
    check("frame_len_default", ev, 32'd40);

    // Reset during WAIT of slice 1 clears outputs at once; next frame restarts at slice 0.
    fill_directed();
    run_frame(1, ev);
    step();
    #2 RESET = 1'b1;
    #1;
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    check("midrst_map", {29'd0, Route_map}, 32'd0);
    check("midrst_starts", {30'd0, Te_start, Ss_start}, 32'd0);
    check("midrst_ready", {31'd0, Counter_ready}, 32'd0);
    RESET = 1'b0;
    step();
    run_frame(-1, ev);
    check("restart_len", ev, 32'd40);

    // Reset and Frame_start together: reset wins.
    RESET = 1'b1;
    Frame_start = 1'b1;
    step();
    RESET = 1'b0;
    Frame_start = 1'b0;
    step();
    check("rst_beats_start", {31'd0, Busy}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      fill_random();
      run_frame(-1, ev);
    end

`ifdef COMPRESS_TIMEOUT_EN
    // Tower slice with Te_done withheld; stray Ss_done must not complete it.
    fill_directed();
    for (int w = 0; w < NC; w++) cnt_val[0][w] = 100;
    run_frame(0, ev);
    for (int i = 1; i <= 64; i++) begin
      step();
      Ss_done = 1'($urandom_range(0, 1));
      Te_done = 1'b0;
      check("to_no_frame_done", {31'd0, Frame_done}, 32'd0);
      if (i == 64) begin
        check("to_err_pre", {31'd0, Err_timeout}, 32'd0);
        check("to_busy_pre", {31'd0, Busy}, 32'd1);
      end
    end
    step();
    idle_inputs();
    check("to_err_set", {31'd0, Err_timeout}, 32'd1);
    check("to_idle", {31'd0, Busy}, 32'd0);
    check("to_no_done", {31'd0, Frame_done}, 32'd0);
    step();
    check("to_err_sticky", {31'd0, Err_timeout}, 32'd1);
    Frame_start = 1'b1;
    step();
    Frame_start = 1'b0;
    check("to_err_cleared", {31'd0, Err_timeout}, 32'd0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
